// File: rtl/vx_issue_scoreboard_if.sv
// vx_issue_scoreboard_if: instruction-buffer head, lookahead and
// writeback commit bundle seen by the issue scoreboard.
interface vx_issue_scoreboard_if #(
    parameter int NW_BITS = 2,
    parameter int NR_BITS = 6
);
    logic               ib_valid;
    logic               ib_ready;
    logic [NW_BITS-1:0] ib_wid;
    logic               ib_wb;
    logic [NR_BITS-1:0] ib_rd;
    logic [NW_BITS-1:0] ib_wid_n;
    logic [NR_BITS-1:0] ib_rd_n;
    logic [NR_BITS-1:0] ib_rs1_n;
    logic [NR_BITS-1:0] ib_rs2_n;
    logic [NR_BITS-1:0] ib_rs3_n;
    logic               wb_valid;
    logic [NW_BITS-1:0] wb_wid;
    logic [NR_BITS-1:0] wb_rd;
    logic               wb_eop;

    modport master (
        output ib_valid, ib_wid, ib_wb, ib_rd,
        output ib_wid_n, ib_rd_n,
        output ib_rs1_n, ib_rs2_n, ib_rs3_n,
        output wb_valid, wb_wid, wb_rd, wb_eop,
        input  ib_ready
    );

    modport slave (
        input  ib_valid, ib_wid, ib_wb, ib_rd,
        input  ib_wid_n, ib_rd_n,
        input  ib_rs1_n, ib_rs2_n, ib_rs3_n,
        input  wb_valid, wb_wid, wb_rd, wb_eop,
        output ib_ready
    );
endinterface

// File: rtl/vx_issue_scoreboard.sv
// vx_issue_scoreboard: per-warp busy-register table gating issue on RAW/WAW.
// Optional stall-timeout monitor: SCOREBOARD_DEADLOCK_CHECK_EN.
module vx_issue_scoreboard #(
    parameter int          NUM_WARPS       = 4,
    parameter int          NUM_REGS        = 64,
    parameter logic [31:0] DEADLOCK_CYCLES = 32'd65535
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_issue_scoreboard_if.slave  sb,
    output logic                  deadlock
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    typedef logic [NUM_REGS-1:0] row_t;

    row_t busy     [NUM_WARPS];
    row_t busy_nxt [NUM_WARPS];
    row_t set_row;
    row_t clr_row;
    row_t row_n;

    logic hazard_r;
    logic hazard_n;
    logic issue_fire;
    logic set_en;
    logic clr_en;

    assign sb.ib_ready  = ~hazard_r;
    assign issue_fire   = sb.ib_valid & sb.ib_ready;
    assign set_en       = issue_fire & sb.ib_wb & (sb.ib_rd != '0);
    assign clr_en       = sb.wb_valid & sb.wb_eop;
    assign set_row      = row_t'(1) << sb.ib_rd;
    assign clr_row      = row_t'(1) << sb.wb_rd;

    // Clear before set so a same-entry collision leaves the entry busy.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            busy_nxt[w] = busy[w];
            if (clr_en && (sb.wb_wid == NW_BITS'(w)))
                busy_nxt[w] = busy_nxt[w] & ~clr_row;
            if (set_en && (sb.ib_wid == NW_BITS'(w)))
                busy_nxt[w] = busy_nxt[w] | set_row;
        end
    end

    // Out-of-range warp ids match no row, so they never hazard.
    always_comb begin
        row_n = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (sb.ib_wid_n == NW_BITS'(w))
                row_n = busy_nxt[w];
        end
    end

    always_comb begin
        hazard_n = ((sb.ib_rs1_n != '0) & row_n[sb.ib_rs1_n])
                 | ((sb.ib_rs2_n != '0) & row_n[sb.ib_rs2_n])
                 | ((sb.ib_rs3_n != '0) & row_n[sb.ib_rs3_n])
                 | ((sb.ib_rd_n  != '0) & row_n[sb.ib_rd_n]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hazard_r <= 1'b0;
            for (int w = 0; w < NUM_WARPS; w++)
                busy[w] <= '0;
        end else begin
            hazard_r <= hazard_n;
            for (int w = 0; w < NUM_WARPS; w++)
                busy[w] <= busy_nxt[w];
        end
    end

    a_no_set_clr_collision : assert property (
        @(posedge clk) disable iff (!reset)
        !(set_en && clr_en &&
          (sb.ib_wid == sb.wb_wid) && (sb.ib_rd == sb.wb_rd))
    ) else $error("vx_issue_scoreboard: set/clear collision wid=%0d rd=%0d",
                  sb.ib_wid, sb.ib_rd);

`ifdef SCOREBOARD_DEADLOCK_CHECK_EN
    logic [31:0] stall_cnt;
    logic        stalled;
    logic        limit_hit;
    row_t        head_row;

    assign stalled   = sb.ib_valid & ~sb.ib_ready;
    assign limit_hit = stalled && ((stall_cnt + 32'd1) >= DEADLOCK_CYCLES);

    always_comb begin
        head_row = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (sb.ib_wid == NW_BITS'(w))
                head_row = busy[w];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            deadlock  <= 1'b0;
        end else begin
            if (!stalled)
                stall_cnt <= '0;
            else if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (limit_hit)
                deadlock <= 1'b1;
        end
    end

    a_no_deadlock : assert property (
        @(posedge clk) disable iff (!reset)
        !(limit_hit && !deadlock)
    ) else $error("vx_issue_scoreboard: deadlock wid=%0d busy=%h",
                  sb.ib_wid, head_row);
`else
    logic unused_deadlock_cfg;

    assign unused_deadlock_cfg = ^DEADLOCK_CYCLES;
    assign deadlock            = 1'b0;
`endif

endmodule
